// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: machine word, multiply/divide opcodes and sequencer states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef logic [1:0] muldiv_state_t;

    localparam muldiv_state_t IDLE = 2'b00;
    localparam muldiv_state_t CALC = 2'b01;
    localparam muldiv_state_t FIX  = 2'b10;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing the HI/LO pair, with MTHI/MTLO access.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO writes accepted
//   CALC  | one shift-add / shift-subtract step per cycle, WORD_W steps
//   FIX   | sign correction, hi/lo write, done pulse
module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  muldiv_op_t        op,
    input  logic [WORD_W-1:0] rs_dat,
    input  logic [WORD_W-1:0] rt_dat,
    input  logic              flush,
    input  logic              hi_wen,
    input  logic              lo_wen,
    input  logic [WORD_W-1:0] wdat,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    muldiv_state_t     state;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              dz;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] dv;

    logic              op_signed;
    logic [WORD_W-1:0] rs_abs;
    logic [WORD_W-1:0] rt_abs;

    logic [WORD_W:0]   add_x;
    logic [WORD_W:0]   add_y;
    logic [WORD_W+1:0] add_res;
    logic [WORD_W:0]   add_sum;
    logic              add_cout;
    logic [WORD_W:0]   mul_s;
    logic [WORD_W-1:0] acc_next;
    logic [WORD_W-1:0] sr_next;

    logic [2*WORD_W-1:0] prod;
    logic [2*WORD_W-1:0] prod_fix;
    logic [WORD_W-1:0]   quo_fix;
    logic [WORD_W-1:0]   rem_fix;

    assign busy      = (state != IDLE);
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign rs_abs    = (op_signed && rs_dat[WORD_W-1]) ? ('0 - rs_dat) : rs_dat;
    assign rt_abs    = (op_signed && rt_dat[WORD_W-1]) ? ('0 - rt_dat) : rt_dat;

    // One WORD_W+1 adder: accumulate for multiply, trial-subtract for divide.
    // For divide the carry out is set exactly when the partial remainder >= divisor.
    assign add_x    = is_div ? {acc, sr[WORD_W-1]} : {1'b0, acc};
    assign add_y    = {1'b0, dv};
    assign add_res  = {1'b0, add_x} + {1'b0, (is_div ? ~add_y : add_y)}
                    + {{(WORD_W+1){1'b0}}, is_div};
    assign add_sum  = add_res[WORD_W:0];
    assign add_cout = add_res[WORD_W+1];

    always_comb begin
        mul_s    = sr[0] ? add_sum : {1'b0, acc};
        acc_next = mul_s[WORD_W:1];
        sr_next  = {mul_s[0], sr[WORD_W-1:1]};
        if (is_div) begin
            acc_next = add_cout ? add_sum[WORD_W-1:0] : add_x[WORD_W-1:0];
            sr_next  = {sr[WORD_W-2:0], add_cout};
        end
    end

    // Divide-by-zero leaves |rs| in the remainder, so the dividend-sign fix restores rs as latched.
    assign prod     = {acc, sr};
    assign prod_fix = neg_q ? ('0 - prod) : prod;
    assign quo_fix  = dz ? '1 : (neg_q ? ('0 - sr) : sr);
    assign rem_fix  = neg_r ? ('0 - acc) : acc;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            acc    <= '0;
            sr     <= '0;
            dv     <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_wen) hi <= wdat;
                    if (lo_wen) lo <= wdat;
                    if (start && !flush) begin
                        is_div <= op[1];
                        neg_q  <= op_signed && (rs_dat[WORD_W-1] ^ rt_dat[WORD_W-1]);
                        neg_r  <= (op == MD_DIV) && rs_dat[WORD_W-1];
                        dz     <= op[1] && (rt_dat == '0);
                        acc    <= '0;
                        sr     <= op[1] ? rs_abs : rt_abs;
                        dv     <= op[1] ? rt_abs : rs_abs;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        acc <= acc_next;
                        sr  <= sr_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WORD_W-1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    cnt   <= '0;
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WORD_W-1:WORD_W];
                            lo <= prod_fix[WORD_W-1:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at start, compared on done.
module tb_muldiv_unit;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       start;
    muldiv_op_t op;
    word_t      rs_dat;
    word_t      rt_dat;
    logic       flush;
    logic       hi_wen;
    logic       lo_wen;
    word_t      wdat;
    logic       busy;
    logic       done;
    word_t      hi;
    word_t      lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    word_t model_hi = '0;
    word_t model_lo = '0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WORD_W(32), .CNT_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op),
        .rs_dat(rs_dat), .rt_dat(rt_dat), .flush(flush),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .wdat(wdat),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input muldiv_op_t o, input word_t a, input word_t b);
        logic signed [63:0] sa, sb, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            MD_MULT:  return sa * sb;
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // kind: 0 normal, 1 flush at cycle 'at', 2 reset at cycle 'at', 3 MTLO attempt at cycle 'at'
    task automatic run_op(input muldiv_op_t o, input word_t a, input word_t b,
                          input int kind, input int at, input bit poke, input string name);
        int busy_n, done_at, pulses;
        bit aborted;
        logic [63:0] e;
        aborted = (kind == 1) || (kind == 2);
        @(negedge CLK);
        op = o; rs_dat = a; rt_dat = b; start = 1'b1;
        if (!aborted) exp_q.push_back(ref_md(o, a, b));
        busy_n = 0; done_at = 0; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            start = 1'b0; flush = 1'b0; nRST = 1'b1; lo_wen = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                pulses++;
                if (done_at == 0) begin
                    done_at = i;
                    chk({name, "_sb_entry"}, 64'(exp_q.size()), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk({name, "_hilo"}, {hi, lo}, e);
                        model_hi = e[63:32];
                        model_lo = e[31:0];
                    end
                end
            end
            if (kind == 3 && i == at + 1) chk({name, "_mtlo_busy"}, 64'(lo), 64'(model_lo));
            if (i == at) begin
                case (kind)
                    1: flush = 1'b1;
                    2: begin nRST = 1'b0; model_hi = '0; model_lo = '0; end
                    3: begin lo_wen = 1'b1; wdat = 32'hDEAD_BEEF; end
                    default: ;
                endcase
            end
            if (poke && i == 5) begin
                start = 1'b1; op = MD_MULTU; rs_dat = 32'd1; rt_dat = 32'd1;
            end
        end
        chk({name, "_busy_cycles"}, 64'(busy_n), aborted ? 64'(at) : 64'd33);
        chk({name, "_done_pulses"}, 64'(pulses), aborted ? 64'd0 : 64'd1);
        chk({name, "_done_cycle"}, 64'(done_at), aborted ? 64'd0 : 64'd34);
        chk({name, "_final_hilo"}, {hi, lo}, {model_hi, model_lo});
    endtask

    task automatic mt_write(input bit wh, input bit wl, input word_t d);
        @(negedge CLK);
        hi_wen = wh; lo_wen = wl; wdat = d;
        @(negedge CLK);
        hi_wen = 1'b0; lo_wen = 1'b0;
        if (wh) model_hi = d;
        if (wl) model_lo = d;
        chk("mt_hilo", {hi, lo}, {model_hi, model_lo});
    endtask

    initial begin
        nRST = 1'b0; start = 1'b0; op = MD_MULT; rs_dat = '0; rt_dat = '0;
        flush = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0; wdat = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        nRST = 1'b1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, "multu_max");
        chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0, "mult_neg");
        chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0, "mult_min");
        chk("mult_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, "div_neg");
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIVU, 32'd100, 32'd7, 0, 0, 1'b0, "divu");
        chk("divu_const", {hi, lo}, {32'd2, 32'd14});
        run_op(MD_DIVU, 32'd5, 32'd0, 0, 0, 1'b0, "divu_zero");
        chk("divu_zero_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op(MD_DIV, 32'hFFFF_FFF6, 32'd0, 0, 0, 1'b0, "div_zero");
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, "div_ovf");
        chk("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});

        mt_write(1'b1, 1'b1, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
        run_op(MD_MULTU, 32'd3, 32'd4, 1, 10, 1'b0, "flush");
        chk("flush_const", {hi, lo}, {32'h11, 32'h22});

        @(negedge CLK);
        op = MD_MULTU; rs_dat = 32'd9; rt_dat = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'd0);
        @(negedge CLK);
        chk("flush_start_idle", {63'd0, busy | done}, 64'd0);

        run_op(MD_MULTU, 32'd5, 32'd6, 0, 0, 1'b1, "ignored_start");
        run_op(MD_MULT, 32'd9, 32'd9, 2, 5, 1'b0, "reset_mid");
        chk("reset_mid_const", {hi, lo}, 64'd0);
        mt_write(1'b1, 1'b0, 32'h1234);
        chk("mthi_const", 64'(hi), 64'h1234);
        run_op(MD_DIVU, 32'd100, 32'd7, 3, 3, 1'b0, "mtlo_busy");

        for (int n = 0; n < 6; n++) begin
            run_op(muldiv_op_t'($urandom_range(0, 3)), $urandom, (n == 2) ? 32'd0 : $urandom,
                   0, 0, 1'b0, "rand");
        end

        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
